// File: rtl/alu_reservation_station.sv
// 16-entry integer ALU reservation station: captures dispatched ops, resolves operand
// tags from both CDB ports and issues the lowest-index ready entry over a registered port.
`ifndef ROB_RANGE
`define ROB_RANGE 4:0
`endif

module alu_reservation_station #(
  parameter int OP_WIDTH = 5
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                flush_in,
  input  logic                dispatch_valid_in,
  input  logic [OP_WIDTH-1:0] dispatch_op_in,
  input  logic [31:0]         dispatch_Vj_in,
  input  logic [31:0]         dispatch_Vk_in,
  input  logic [`ROB_RANGE]   dispatch_Qj_in,
  input  logic [`ROB_RANGE]   dispatch_Qk_in,
  input  logic [`ROB_RANGE]   dispatch_rob_id_in,
  input  logic [`ROB_RANGE]   cdb_alu_rob_id_in,
  input  logic [`ROB_RANGE]   cdb_mem_rob_id_in,
  input  logic [31:0]         cdb_alu_value_in,
  input  logic [31:0]         cdb_mem_value_in,
  output logic                full_out,
  output logic                alu_valid_out,
  output logic [OP_WIDTH-1:0] alu_op_out,
  output logic [31:0]         alu_a_out,
  output logic [31:0]         alu_b_out,
  output logic [`ROB_RANGE]   alu_rob_id_out
);

  localparam int unsigned DEPTH = 16;

  typedef logic [`ROB_RANGE] rob_t;
  typedef struct packed {
    rob_t        q;
    logic [31:0] v;
  } operand_t;

  logic [DEPTH-1:0]    busy_q, busy_d;
  logic [OP_WIDTH-1:0] op_q [DEPTH];
  logic [OP_WIDTH-1:0] op_d [DEPTH];
  logic [31:0]         vj_q [DEPTH];
  logic [31:0]         vj_d [DEPTH];
  logic [31:0]         vk_q [DEPTH];
  logic [31:0]         vk_d [DEPTH];
  rob_t                qj_q [DEPTH];
  rob_t                qj_d [DEPTH];
  rob_t                qk_q [DEPTH];
  rob_t                qk_d [DEPTH];
  rob_t                rob_q [DEPTH];
  rob_t                rob_d [DEPTH];

  logic                full_q, full_d;
  logic                valid_q, valid_d;
  logic [OP_WIDTH-1:0] alu_op_q, alu_op_d;
  logic [31:0]         alu_a_q, alu_a_d;
  logic [31:0]         alu_b_q, alu_b_d;
  rob_t                alu_rob_q, alu_rob_d;

  logic       issue_any, vacant_any;
  logic [3:0] issue_idx, vacant_idx;
  operand_t   disp_j, disp_k, upd_j, upd_k;

  // ALU broadcast takes priority when both ports carry the awaited tag.
  function automatic operand_t resolve(input rob_t q, input logic [31:0] v,
                                       input rob_t alu_id, input logic [31:0] alu_v,
                                       input rob_t mem_id, input logic [31:0] mem_v);
    operand_t r;
    r.q = q;
    r.v = v;
    if (q != '0) begin
      if (q == alu_id) begin
        r.q = '0;
        r.v = alu_v;
      end else if (q == mem_id) begin
        r.q = '0;
        r.v = mem_v;
      end
    end
    return r;
  endfunction

  always_comb begin
    issue_any  = 1'b0;
    issue_idx  = '0;
    vacant_any = 1'b0;
    vacant_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!issue_any && busy_q[i] && qj_q[i] == '0 && qk_q[i] == '0) begin
        issue_any = 1'b1;
        issue_idx = 4'(i);
      end
      if (!vacant_any && !busy_q[i]) begin
        vacant_any = 1'b1;
        vacant_idx = 4'(i);
      end
    end
  end

  always_comb begin
    busy_d    = busy_q;
    op_d      = op_q;
    vj_d      = vj_q;
    vk_d      = vk_q;
    qj_d      = qj_q;
    qk_d      = qk_q;
    rob_d     = rob_q;
    full_d    = full_q;
    valid_d   = 1'b0;
    alu_op_d  = alu_op_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_rob_d = alu_rob_q;
    upd_j     = '0;
    upd_k     = '0;
    disp_j    = resolve(dispatch_Qj_in, dispatch_Vj_in, cdb_alu_rob_id_in, cdb_alu_value_in,
                        cdb_mem_rob_id_in, cdb_mem_value_in);
    disp_k    = resolve(dispatch_Qk_in, dispatch_Vk_in, cdb_alu_rob_id_in, cdb_alu_value_in,
                        cdb_mem_rob_id_in, cdb_mem_value_in);
    if (rdy_in) begin
      if (flush_in) begin
        busy_d = '0;
        full_d = 1'b0;
      end else begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          upd_j = resolve(qj_q[i], vj_q[i], cdb_alu_rob_id_in, cdb_alu_value_in,
                          cdb_mem_rob_id_in, cdb_mem_value_in);
          upd_k = resolve(qk_q[i], vk_q[i], cdb_alu_rob_id_in, cdb_alu_value_in,
                          cdb_mem_rob_id_in, cdb_mem_value_in);
          qj_d[i] = upd_j.q;
          vj_d[i] = upd_j.v;
          qk_d[i] = upd_k.q;
          vk_d[i] = upd_k.v;
        end
        if (issue_any) begin
          busy_d[issue_idx] = 1'b0;
          valid_d   = 1'b1;
          alu_op_d  = op_q[issue_idx];
          alu_a_d   = vj_q[issue_idx];
          alu_b_d   = vk_q[issue_idx];
          alu_rob_d = rob_q[issue_idx];
        end
        // Vacancy is taken pre-edge, so the slot just issued is never the target here.
        if (dispatch_valid_in && vacant_any) begin
          busy_d[vacant_idx] = 1'b1;
          op_d[vacant_idx]   = dispatch_op_in;
          rob_d[vacant_idx]  = dispatch_rob_id_in;
          qj_d[vacant_idx]   = disp_j.q;
          vj_d[vacant_idx]   = disp_j.v;
          qk_d[vacant_idx]   = disp_k.q;
          vk_d[vacant_idx]   = disp_k.v;
        end
        full_d = &busy_d;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q    <= '0;
      full_q    <= 1'b0;
      valid_q   <= 1'b0;
      alu_op_q  <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_rob_q <= '0;
    end else begin
      busy_q    <= busy_d;
      full_q    <= full_d;
      valid_q   <= valid_d;
      alu_op_q  <= alu_op_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_rob_q <= alu_rob_d;
    end
  end

  always_ff @(posedge clk_in) begin
    op_q  <= op_d;
    vj_q  <= vj_d;
    vk_q  <= vk_d;
    qj_q  <= qj_d;
    qk_q  <= qk_d;
    rob_q <= rob_d;
  end

  assign full_out       = full_q;
  assign alu_valid_out  = valid_q;
  assign alu_op_out     = alu_op_q;
  assign alu_a_out      = alu_a_q;
  assign alu_b_out      = alu_b_q;
  assign alu_rob_id_out = alu_rob_q;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station with immediate-assertion checks.
`ifndef ROB_RANGE
`define ROB_RANGE 4:0
`endif

module tb_alu_reservation_station;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              rdy_in;
  logic              flush_in;
  logic              dispatch_valid_in;
  logic [4:0]        dispatch_op_in;
  logic [31:0]       dispatch_Vj_in, dispatch_Vk_in;
  logic [`ROB_RANGE] dispatch_Qj_in, dispatch_Qk_in, dispatch_rob_id_in;
  logic [`ROB_RANGE] cdb_alu_rob_id_in, cdb_mem_rob_id_in;
  logic [31:0]       cdb_alu_value_in, cdb_mem_value_in;
  logic              full_out, alu_valid_out;
  logic [4:0]        alu_op_out;
  logic [31:0]       alu_a_out, alu_b_out;
  logic [`ROB_RANGE] alu_rob_id_out;

  int vectors = 0;
  int miscompares = 0;

  alu_reservation_station #(.OP_WIDTH(5)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .dispatch_valid_in(dispatch_valid_in), .dispatch_op_in(dispatch_op_in),
    .dispatch_Vj_in(dispatch_Vj_in), .dispatch_Vk_in(dispatch_Vk_in),
    .dispatch_Qj_in(dispatch_Qj_in), .dispatch_Qk_in(dispatch_Qk_in),
    .dispatch_rob_id_in(dispatch_rob_id_in),
    .cdb_alu_rob_id_in(cdb_alu_rob_id_in), .cdb_mem_rob_id_in(cdb_mem_rob_id_in),
    .cdb_alu_value_in(cdb_alu_value_in), .cdb_mem_value_in(cdb_mem_value_in),
    .full_out(full_out), .alu_valid_out(alu_valid_out), .alu_op_out(alu_op_out),
    .alu_a_out(alu_a_out), .alu_b_out(alu_b_out), .alu_rob_id_out(alu_rob_id_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic disp(input logic [4:0] op, input logic [31:0] vj, input logic [31:0] vk,
                      input logic [4:0] qj, input logic [4:0] qk, input logic [4:0] rob);
    dispatch_valid_in  = 1'b1;
    dispatch_op_in     = op;
    dispatch_Vj_in     = vj;
    dispatch_Vk_in     = vk;
    dispatch_Qj_in     = qj;
    dispatch_Qk_in     = qk;
    dispatch_rob_id_in = rob;
  endtask

  task automatic idle();
    dispatch_valid_in = 1'b0;
    cdb_alu_rob_id_in = '0;
    cdb_mem_rob_id_in = '0;
    cdb_alu_value_in  = '0;
    cdb_mem_value_in  = '0;
  endtask

  initial begin
    rst_in = 1'b0;
    rdy_in = 1'b1;
    flush_in = 1'b0;
    disp(5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    idle();
    step();
    step();
    chk("reset_valid", {31'd0, alu_valid_out}, 32'd0);
    chk("reset_full", {31'd0, full_out}, 32'd0);
    chk("reset_rob", {27'd0, alu_rob_id_out}, 32'd0);
    chk("reset_a", alu_a_out, 32'd0);
    rst_in = 1'b1;

    // Basic two-edge latency
    disp(5'd3, 32'd5, 32'd7, 5'd0, 5'd0, 5'd2);
    step();
    idle();
    chk("t1_no_issue_on_dispatch", {31'd0, alu_valid_out}, 32'd0);
    step();
    chk("t1_valid", {31'd0, alu_valid_out}, 32'd1);
    chk("t1_op", {27'd0, alu_op_out}, 32'd3);
    chk("t1_a", alu_a_out, 32'd5);
    chk("t1_b", alu_b_out, 32'd7);
    chk("t1_rob", {27'd0, alu_rob_id_out}, 32'd2);
    step();
    chk("t1_valid_drop", {31'd0, alu_valid_out}, 32'd0);
    chk("t1_a_hold", alu_a_out, 32'd5);

    // Wakeup via ALU CDB
    disp(5'd1, 32'd0, 32'd9, 5'd4, 5'd0, 5'd6);
    step();
    idle();
    step();
    chk("t2_waiting", {31'd0, alu_valid_out}, 32'd0);
    cdb_alu_rob_id_in = 5'd4;
    cdb_alu_value_in  = 32'h11;
    step();
    idle();
    chk("t2_not_on_cdb_edge", {31'd0, alu_valid_out}, 32'd0);
    step();
    chk("t2_valid", {31'd0, alu_valid_out}, 32'd1);
    chk("t2_a", alu_a_out, 32'h11);
    chk("t2_b", alu_b_out, 32'd9);
    chk("t2_rob", {27'd0, alu_rob_id_out}, 32'd6);
    step();

    // Same-cycle capture from MEM CDB during dispatch
    disp(5'd2, 32'd1, 32'd0, 5'd0, 5'd5, 5'd8);
    cdb_mem_rob_id_in = 5'd5;
    cdb_mem_value_in  = 32'hAB;
    step();
    idle();
    step();
    chk("t3_valid", {31'd0, alu_valid_out}, 32'd1);
    chk("t3_a", alu_a_out, 32'd1);
    chk("t3_b", alu_b_out, 32'hAB);
    chk("t3_rob", {27'd0, alu_rob_id_out}, 32'd8);
    step();

    // Both CDB ports carry the awaited tag
    disp(5'd4, 32'd0, 32'd4, 5'd3, 5'd0, 5'd9);
    step();
    idle();
    cdb_alu_rob_id_in = 5'd3;
    cdb_alu_value_in  = 32'd1;
    cdb_mem_rob_id_in = 5'd3;
    cdb_mem_value_in  = 32'd2;
    step();
    idle();
    step();
    chk("t4_valid", {31'd0, alu_valid_out}, 32'd1);
    chk("t4_alu_wins", alu_a_out, 32'd1);
    chk("t4_rob", {27'd0, alu_rob_id_out}, 32'd9);
    step();
    chk("t4_empty", {31'd0, alu_valid_out}, 32'd0);

    // Fill all slots, waiting on tag 7
    for (int i = 0; i < 16; i++) begin
      disp(5'd5, 32'd0, 32'(i), 5'd7, 5'd0, 5'(i + 1));
      step();
      if (i == 14) chk("fill_not_full_15", {31'd0, full_out}, 32'd0);
    end
    chk("fill_full_16", {31'd0, full_out}, 32'd1);
    disp(5'd5, 32'd0, 32'd99, 5'd0, 5'd0, 5'd20);
    step();
    idle();
    chk("fill_drop_full", {31'd0, full_out}, 32'd1);
    chk("fill_drop_valid", {31'd0, alu_valid_out}, 32'd0);
    cdb_alu_rob_id_in = 5'd7;
    cdb_alu_value_in  = 32'h100;
    step();
    idle();
    chk("fill_wake_no_issue", {31'd0, alu_valid_out}, 32'd0);
    for (int k = 0; k < 16; k++) begin
      if (k == 4) begin
        rdy_in = 1'b0;
        step();
        chk("stall_valid", {31'd0, alu_valid_out}, 32'd0);
        chk("stall_rob_hold", {27'd0, alu_rob_id_out}, 32'd4);
        rdy_in = 1'b1;
      end
      step();
      chk("drain_valid", {31'd0, alu_valid_out}, 32'd1);
      chk("drain_rob", {27'd0, alu_rob_id_out}, 32'(k + 1));
      chk("drain_b", alu_b_out, 32'(k));
      if (k == 0) chk("drain_full_drop", {31'd0, full_out}, 32'd0);
    end
    step();
    chk("drain_done", {31'd0, alu_valid_out}, 32'd0);

    // Flush with concurrent dispatch and a pending issue
    disp(5'd6, 32'd0, 32'd0, 5'd9, 5'd0, 5'd13);
    step();
    disp(5'd6, 32'd0, 32'd0, 5'd0, 5'd0, 5'd14);
    step();
    disp(5'd6, 32'd0, 32'd0, 5'd0, 5'd0, 5'd12);
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    idle();
    chk("flush_valid", {31'd0, alu_valid_out}, 32'd0);
    chk("flush_full", {31'd0, full_out}, 32'd0);
    cdb_alu_rob_id_in = 5'd9;
    cdb_alu_value_in  = 32'h5;
    step();
    idle();
    chk("flush_after1", {31'd0, alu_valid_out}, 32'd0);
    step();
    chk("flush_after2", {31'd0, alu_valid_out}, 32'd0);
    step();
    chk("flush_after3", {31'd0, alu_valid_out}, 32'd0);

    // Asynchronous reset between edges
    disp(5'd7, 32'h33, 32'h44, 5'd0, 5'd0, 5'd15);
    step();
    idle();
    step();
    chk("pre_reset_valid", {31'd0, alu_valid_out}, 32'd1);
    chk("pre_reset_rob", {27'd0, alu_rob_id_out}, 32'd15);
    #2;
    rst_in = 1'b0;
    #1;
    chk("async_valid", {31'd0, alu_valid_out}, 32'd0);
    chk("async_rob", {27'd0, alu_rob_id_out}, 32'd0);
    chk("async_a", alu_a_out, 32'd0);
    chk("async_op", {27'd0, alu_op_out}, 32'd0);
    rst_in = 1'b1;
    step();
    chk("post_reset_full", {31'd0, full_out}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
